// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier:
// FSM encoding, default operand width and Booth recoding pairs.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // {Qreg[0], q_1} patterns that trigger a subtract or an add of M
  localparam logic [1:0] PAIR_SUB = 2'b10;
  localparam logic [1:0] PAIR_ADD = 2'b01;

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Request/result bundle between the operand source and the Booth controller.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of M
// followed by an arithmetic right shift of {A, Qreg, q_1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH:0]   a,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_1,
  input  logic signed [WIDTH:0]   m,
  output logic signed [WIDTH:0]   a_next,
  output logic        [WIDTH-1:0] q_next,
  output logic                    q_1_next
);

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_1})
      PAIR_SUB: sum = a - m;
      PAIR_ADD: sum = a + m;
      default:  sum = a;
    endcase
    a_next   = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the Booth multiplier: start edge detection,
// operand capture, WIDTH iterations and a registered product with done pulse.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  booth_seq_ctrl_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 state_reg, state_next;
  logic                   start_d_reg;
  logic                   start_pe;
  logic signed [WIDTH:0]  m_reg, m_next;
  logic signed [WIDTH:0]  a_reg, a_next;
  logic [WIDTH-1:0]       q_reg, q_next;
  logic                   q1_reg, q1_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [2*WIDTH-1:0]     product_reg, product_next;

  logic signed [WIDTH:0]  step_a;
  logic [WIDTH-1:0]       step_q;
  logic                   step_q1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_reg),
    .q        (q_reg),
    .q_1      (q1_reg),
    .m        (m_reg),
    .a_next   (step_a),
    .q_next   (step_q),
    .q_1_next (step_q1)
  );

  assign start_pe = bus.start & ~start_d_reg;

  always_comb begin
    state_next   = state_reg;
    m_next       = m_reg;
    a_next       = a_reg;
    q_next       = q_reg;
    q1_next      = q1_reg;
    count_next   = count_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE: begin
        if (start_pe) begin
          m_next     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          a_next     = '0;
          q_next     = bus.multiplier;
          q1_next    = 1'b0;
          count_next = CW'(WIDTH);
          state_next = CALC;
        end
      end
      CALC: begin
        a_next     = step_a;
        q_next     = step_q;
        q1_next    = step_q1;
        count_next = count_reg - 1'b1;
        if (count_reg == CW'(1)) begin
          // Lower 2*WIDTH bits suffice: the full-precision result always fits.
          product_next = {step_a[WIDTH-1:0], step_q};
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // start_d resets high so a start held through reset does not launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_d_reg <= 1'b1;
      m_reg       <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      q1_reg      <= 1'b0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      start_d_reg <= bus.start;
      m_reg       <= m_next;
      a_reg       <= a_next;
      q_reg       <= q_next;
      q1_reg      <= q1_next;
      count_reg   <= count_next;
      product_reg <= product_next;
    end
  end

  assign bus.busy    = (state_reg == CALC);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = product_reg;

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Sequencing controller for the radix-2 Booth multiplier datapath.
- Turns a level start request into a single operation by detecting its rising edge internally.
- Captures both signed operands, then runs WIDTH add/subtract-and-shift iterations.
- Presents the signed product with a one-cycle done pulse.
- Sits between the board-level button/switch logic and the multiplier result display.

Parameters:
WIDTH, 8, operand width in bits; operands are two's complement; minimum 2.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  level request; only a rising edge (start=1 now, 0 on previous clk) launches an operation
multiplicand  input  WIDTH  signed operand M, sampled on the launch edge
multiplier  input  WIDTH  signed operand Q, sampled on the launch edge
busy  output  1  high while an operation is in progress (CALC state)
done  output  1  one-cycle pulse when product becomes valid
product  output  2*WIDTH  signed M*Q, held until the next launch

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; product=0; count=0; A=0; Qreg=0; q_1=0; start_d=1.
- start_d resets to 1 so that a start held high through reset does not launch.
- start_pe = start & ~start_d. start_d <= start every clk.
- States: IDLE, CALC, DONE.
- IDLE:
  - On a clk edge with start_pe=1: Mreg<=multiplicand sign-extended to WIDTH+1; A<=0; Qreg<=multiplier; q_1<=0; count<=WIDTH; go to CALC.
  - Otherwise remain in IDLE.
- CALC (busy=1), one Booth step per cycle:
  - pair {Qreg[0],q_1}: 10 -> A-Mreg; 01 -> A+Mreg; 00/11 -> A unchanged.
  - Arithmetic right shift of {A',Qreg,q_1} by one; A is WIDTH+1 bits, so the multiplicand -2^(WIDTH-1) cannot overflow.
  - count <= count-1.
  - When count==1 on entry to the step, this is the last step: go to DONE.
- DONE (busy=0, done=1 for exactly one cycle):
  - product <= lower 2*WIDTH bits of {A,Qreg} as produced by the final step; registered on entry to DONE, so it is visible in the same cycle done=1.
  - Next state is IDLE unconditionally.
- Latency: launch edge at cycle t -> busy high cycles t+1..t+WIDTH -> done=1 and product valid in cycle t+WIDTH+1.
- Back-to-back: the earliest next launch is a start_pe seen in IDLE, at cycle t+WIDTH+2 or later.
- start_pe in CALC or DONE: ignored, not queued. start_d still tracks start, so a level held across the operation never relaunches.
- Operand inputs may change freely after the launch edge; only the captured values are used.
- product holds its last value through IDLE and CALC. It changes only on DONE entry or on reset.
- Reset mid-operation: immediate abort to IDLE, all outputs cleared, no done pulse.
- Arithmetic is full-precision signed: result range -2^(2W-2)+2^(W-1) .. 2^(2W-2). E.g. (-128)*(-128)=16384 fits in 16 bits.

Decomposition:
- Shared package booth_pkg holds:
  - the state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the default WIDTH;
  - the Booth recoding constants for the pairs 10 and 01.
- One natural sub-module, booth_step: purely combinational, WIDTH parameter. Inputs A, Qreg, q_1, Mreg; outputs next A, Qreg, q_1.
- The controller instantiates booth_step and owns all registers, the counter and the start edge detection.

Test Plan:
- WIDTH=8, M=3, Q=5, one start pulse -> busy high 8 cycles, done one cycle at launch+9, product=16'd15.
- M=-7, Q=6 -> product=16'hFFD6 (-42). M=-128, Q=-128 -> product=16'h4000 (16384). M=0, Q=-1 -> product=0.
- start held high 30 cycles with M=4, Q=4 -> exactly one done pulse; product=16; busy never re-asserts.
- Launch M=2, Q=3; toggle start 0->1 at launch+4 with operands changed to 9,9 -> edge ignored; product=6; single done.
- Launch M=5, Q=5; assert rst at launch+3 -> busy=0, product=0, no done. After release, launch M=-1, Q=1 -> product=16'hFFFF.
- start=1 throughout reset, rst deasserted -> no operation until start falls and rises again.
